// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM encodings, parity modes, oversampling ratio.
// No logic, constants only.
// Not applicable (no datapath).
package uart_pkg;

    // Bit-period oversampling ratio of the baud-rate generator tick
    localparam int OVERSAMPLE = 16;

    // Parity selection; any other value behaves as none
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // FSM state encodings shared by transmitter and receiver
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, D_BIT data bits LSB first, optional parity, stop bit(s) on o_tx.
// Line goes low 1 clock after acceptance; every bit lasts 16 ticks, stop lasts SB_TICK ticks.
// No queueing: i_tx_start is honoured only while idle, producer waits for o_tx_busy = 0.
module transmitter
    import uart_pkg::*;
#(
    parameter int D_BIT   = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_s_tick,
    input  logic             i_tx_start,
    input  logic [D_BIT-1:0] i_data,
    output logic             o_tx_done_tick,
    output logic             o_tx_busy,
    output logic             o_tx
);

    // Tick counter must hold both a full bit period and the longest stop period
    localparam int S_W = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int N_W = $clog2(D_BIT);

    localparam bit             PAR_EN      = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(D_BIT - 1);

    logic [2:0]       state_q;
    logic [S_W-1:0]   s_q;
    logic [N_W-1:0]   n_q;
    logic [D_BIT-1:0] b_q;
    logic             par_q;
    logic             tx_q;

    // Frame sequencer; tx_q is loaded with the level of the state being entered so the line is a clean flop output
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (i_tx_start) begin
                        b_q     <= i_data;
                        s_q     <= '0;
                        par_q   <= (PARITY == PARITY_ODD) ? ~^i_data : ^i_data;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            tx_q    <= b_q[0];
                            state_q <= ST_DATA;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q <= '0;
                            b_q <= b_q >> 1;
                            if (n_q == N_LAST) begin
                                if (PAR_EN) begin
                                    tx_q    <= par_q;
                                    state_q <= ST_PARITY;
                                end else begin
                                    tx_q    <= 1'b1;
                                    state_q <= ST_STOP;
                                end
                            end else begin
                                n_q  <= n_q + 1'b1;
                                tx_q <= b_q[1];
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_s_tick) begin
                        if (s_q == S_BIT_LAST) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_s_tick) begin
                        if (s_q == S_STOP_LAST) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Done marks the final stop tick itself, so busy is still high in that cycle
    assign o_tx_done_tick = (state_q == ST_STOP) && i_s_tick && (s_q == S_STOP_LAST);
    assign o_tx_busy      = (state_q != ST_IDLE);
    assign o_tx           = tx_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the UART transmitter: three instances (no/even/odd parity) share stimulus.
// Frames are captured per tick and compared against hand-computed bit patterns.
// A behavioural receiver checks random back-to-back frames on the no-parity instance.
module tb_transmitter;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic [2:0] tx_start;
    logic [7:0] data;
    logic [2:0] done_w, busy_w, tx_w;

    always #5 clk = ~clk;

    transmitter #(.D_BIT(8), .SB_TICK(16), .PARITY(PARITY_NONE)) u_tx0 (
        .i_clock(clk), .i_reset(rst), .i_s_tick(s_tick), .i_tx_start(tx_start[0]), .i_data(data),
        .o_tx_done_tick(done_w[0]), .o_tx_busy(busy_w[0]), .o_tx(tx_w[0]));
    transmitter #(.D_BIT(8), .SB_TICK(16), .PARITY(PARITY_EVEN)) u_tx1 (
        .i_clock(clk), .i_reset(rst), .i_s_tick(s_tick), .i_tx_start(tx_start[1]), .i_data(data),
        .o_tx_done_tick(done_w[1]), .o_tx_busy(busy_w[1]), .o_tx(tx_w[1]));
    transmitter #(.D_BIT(8), .SB_TICK(16), .PARITY(PARITY_ODD)) u_tx2 (
        .i_clock(clk), .i_reset(rst), .i_s_tick(s_tick), .i_tx_start(tx_start[2]), .i_data(data),
        .o_tx_done_tick(done_w[2]), .o_tx_busy(busy_w[2]), .o_tx(tx_w[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Per-instance capture of the line on tick cycles while busy
    logic smp [0:2][0:255];
    int   ns [0:2];
    int   done_cnt [0:2];
    int   done_at [0:2];
    bit   cap_en = 1'b0;

    // One clock: drive inputs, sample mid-cycle, return 1 time unit after the next rising edge
    task automatic cyc(input logic tk, input logic [2:0] st);
        s_tick   = tk;
        tx_start = st;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (cap_en && tk && busy_w[k]) begin
                if (ns[k] < 256) smp[k][ns[k]] = tx_w[k];
                ns[k]++;
            end
            if (done_w[k]) begin
                done_cnt[k]++;
                done_at[k] = ns[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) begin
            ns[k] = 0;
            done_cnt[k] = 0;
            done_at[k] = -1;
            for (int i = 0; i < 256; i++) smp[k][i] = 1'bx;
        end
    endtask

    // mode 0: single start pulse; 1: start held until the done cycle; 2: start on every tick incl. done cycle
    task automatic run_frame(input string name, input logic [7:0] d, input int div, input int mode,
                             input logic [10:0] e0, input logic [10:0] e1, input logic [10:0] e2);
        logic [10:0] exp_b [0:2];
        logic [10:0] got;
        logic        incons;
        logic        tk;
        logic [2:0]  st;
        int          nb;
        int          c;
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        clear_counts();
        cap_en = 1'b1;
        data = d;
        cyc(1'b0, 3'b111);
        check($sformatf("%s busy after accept", name), 32'(busy_w), 32'h7);
        data = ~d;
        c = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && c < 180 * div + 20) begin
            tk = ((c % div) == (div - 1));
            for (int k = 0; k < 3; k++)
                st[k] = (mode == 1) ? (done_cnt[k] == 0) :
                        (mode == 2) ? (tk && done_cnt[k] == 0) : 1'b0;
            cyc(tk, st);
            c++;
        end
        cap_en   = 1'b0;
        tx_start = 3'b000;
        for (int k = 0; k < 3; k++) begin
            nb     = (k == 0) ? 10 : 11;
            got    = '0;
            incons = 1'b0;
            for (int i = 0; i < nb; i++) begin
                got[i] = smp[k][i * 16];
                for (int j = 1; j < 16; j++)
                    if (smp[k][i * 16 + j] !== smp[k][i * 16]) incons = 1'b1;
            end
            check($sformatf("%s dut%0d bits", name, k), {20'h0, incons, got}, {21'h0, exp_b[k]});
            check($sformatf("%s dut%0d done tick", name, k), 32'(done_at[k]), (k == 0) ? 32'd160 : 32'd176);
            check($sformatf("%s dut%0d done count", name, k), 32'(done_cnt[k]), 32'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  d;
        int          div;
        logic [10:0] e0;
        logic [10:0] e1;
        logic [10:0] e2;
    } vec_t;

    vec_t tbl [0:4];

    // Behavioural mid-bit sampling receiver on the no-parity line
    bit         rx_en = 1'b0;
    int         rx_st, rx_s, rx_n, rx_cnt;
    logic [7:0] rx_b;
    logic [7:0] sent_q [$];
    logic [7:0] rx_exp;

    // Receiver model advances on every tick while enabled
    always @(negedge clk) begin
        if (!rx_en) begin
            rx_st = 0;
        end else if (s_tick) begin
            case (rx_st)
                0: if (tx_w[0] == 1'b0) begin rx_st = 1; rx_s = 0; end
                1: if (rx_s == 7) begin rx_st = 2; rx_s = 0; rx_n = 0; end else rx_s++;
                2: if (rx_s == 15) begin
                       rx_s = 0;
                       rx_b = {tx_w[0], rx_b[7:1]};
                       if (rx_n == 7) rx_st = 3; else rx_n++;
                   end else rx_s++;
                3: if (rx_s == 15) begin
                       rx_st = 0;
                       if (sent_q.size() > 0) rx_exp = sent_q.pop_front();
                       else rx_exp = 8'hxx;
                       check($sformatf("loopback frame %0d", rx_cnt), {23'h0, tx_w[0], rx_b}, {23'h0, 1'b1, rx_exp});
                       rx_cnt++;
                   end else rx_s++;
                default: rx_st = 0;
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam int LB_FRAMES = 300;

    initial begin
        int   bad;
        int   w;
        int   tmo;
        logic [7:0] d;

        tbl[0] = '{"A5 div1", 8'hA5, 1, 11'h34A, 11'h54A, 11'h74A};
        tbl[1] = '{"07 div2", 8'h07, 2, 11'h20E, 11'h60E, 11'h40E};
        tbl[2] = '{"00 div3", 8'h00, 3, 11'h200, 11'h400, 11'h600};
        tbl[3] = '{"FF div2", 8'hFF, 2, 11'h3FE, 11'h5FE, 11'h7FE};
        tbl[4] = '{"80 div1", 8'h80, 1, 11'h300, 11'h700, 11'h500};

        rst = 1'b1; s_tick = 1'b0; tx_start = 3'b000; data = 8'h00;
        clear_counts();
        repeat (3) cyc(1'b0, 3'b000);
        check("reset tx", 32'(tx_w), 32'h7);
        check("reset busy", 32'(busy_w), 32'h0);
        check("reset done", 32'(done_w), 32'h0);
        rst = 1'b0;

        // Ticks in idle must leave the line high and the FSM idle
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 3'b000);
            if (tx_w !== 3'b111 || busy_w !== 3'b000) bad++;
        end
        check("idle ticks line/busy", 32'(bad), 32'd0);
        check("idle ticks done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);

        for (int v = 0; v < 5; v++)
            run_frame(tbl[v].name, tbl[v].d, tbl[v].div, 0, tbl[v].e0, tbl[v].e1, tbl[v].e2);

        // Start held across the whole frame: exactly one frame
        run_frame("hold C3", 8'hC3, 2, 1, 11'h386, 11'h586, 11'h786);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 3'b000);
            if (busy_w !== 3'b000) bad++;
        end
        check("hold no second frame", 32'(bad), 32'd0);
        check("hold no extra done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd3);

        // Start in the done cycle ignored, start on the following cycle accepted
        run_frame("done-cycle 3C", 8'h3C, 2, 2, 11'h278, 11'h478, 11'h678);
        run_frame("back-to-back 96", 8'h96, 2, 0, 11'h32C, 11'h52C, 11'h72C);

        // Reset in the middle of the data state
        clear_counts();
        data = 8'h00;
        cyc(1'b0, 3'b111);
        data = 8'hFF;
        for (int i = 0; i < 40; i++) cyc(1'b1, 3'b000);
        check("pre-reset line in data", 32'(tx_w), 32'h0);
        rst = 1'b1;
        cyc(1'b1, 3'b000);
        check("mid-frame reset tx", 32'(tx_w), 32'h7);
        check("mid-frame reset busy", 32'(busy_w), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) cyc(1'b1, 3'b000);
        check("mid-frame reset no done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
        run_frame("after reset 5A", 8'h5A, 1, 0, 11'h2B4, 11'h4B4, 11'h6B4);

        // Loopback of random bytes, back-to-back, tick every cycle
        rx_cnt = 0;
        rx_en  = 1'b1;
        tmo    = 0;
        for (int f = 0; f < LB_FRAMES; f++) begin
            w = 0;
            while (busy_w[0] && w < 400) begin
                cyc(1'b1, 3'b000);
                w++;
            end
            if (w >= 400) tmo++;
            d = 8'($urandom);
            sent_q.push_back(d);
            data = d;
            cyc(1'b1, 3'b001);
        end
        w = 0;
        while (rx_cnt < LB_FRAMES && w < 400) begin
            cyc(1'b1, 3'b000);
            w++;
        end
        check("loopback wait timeouts", 32'(tmo), 32'd0);
        check("loopback frames received", 32'(rx_cnt), 32'(LB_FRAMES));
        rx_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
